// File: rtl/pc_gen_pkg.sv
// pc_pkg: shared state encoding and default parameters for the pc_gen fetch PC generator.
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_e;
  localparam int DEF_XLEN = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
  localparam int DEF_INC = 4;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request bus between pc_gen (master) and instruction fetch (slave).
interface pc_gen_if #(parameter int XLEN = 32);
  logic            i_ready;
  logic            i_stall;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            i_trap;
  logic            i_halt;
  logic            i_resume;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_pc_inc;
  logic            o_valid;
  logic            o_halted;
  logic            o_misalign;
  modport master (
    input  i_ready, i_stall, i_redirect, i_redirect_pc, i_trap, i_halt, i_resume,
    output o_pc, o_pc_inc, o_valid, o_halted, o_misalign
  );
  modport slave (
    output i_ready, i_stall, i_redirect, i_redirect_pc, i_trap, i_halt, i_resume,
    input  o_pc, o_pc_inc, o_valid, o_halted, o_misalign
  );
endinterface

// File: rtl/pc_gen_next_sel.sv
// pc_next_sel: next-PC priority mux (trap > redirect > increment); PC_GEN_ALIGN_CHECK_EN adds misaligned-redirect trapping.
module pc_next_sel import pc_pkg::*; #(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC),
  parameter int              INC      = DEF_INC
) (
  input  pc_state_e       state,
  input  logic [XLEN-1:0] pc,
  input  logic            ready,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_inc,
  output logic            misalign
);
  logic redir_ok;
  assign pc_inc = pc + XLEN'(INC);
  assign redir_ok = redirect && (state == RUN || state == HALT);
`ifdef PC_GEN_ALIGN_CHECK_EN
  assign misalign = redir_ok && |(redirect_pc & XLEN'(INC - 1));
`else
  assign misalign = 1'b0;
`endif
  assign pc_next = (trap || misalign) ? TRAP_VEC :
                   redir_ok ? redirect_pc :
                   (state == RUN && ready && !stall) ? pc_inc : pc;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage PC generator with BOOT/RUN/HALT control; optional PC_GEN_ALIGN_CHECK_EN traps misaligned redirects.
module pc_gen import pc_pkg::*; #(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              INC       = DEF_INC
) (
  input logic    i_clk,
  input logic    i_rst,
  pc_gen_if.master bus
);
  pc_state_e state, st, state_next;
  logic [XLEN-1:0] pc, pc_next, pc_inc;
  logic misalign, misalign_q;
  // undefined encodings behave exactly like BOOT
  assign st = (state == RUN || state == HALT) ? state : BOOT;
  pc_next_sel #(.XLEN(XLEN), .TRAP_VEC(TRAP_VEC), .INC(INC)) u_sel (
    .state(st),
    .pc(pc),
    .ready(bus.i_ready),
    .stall(bus.i_stall),
    .redirect(bus.i_redirect),
    .redirect_pc(bus.i_redirect_pc),
    .trap(bus.i_trap),
    .pc_next(pc_next),
    .pc_inc(pc_inc),
    .misalign(misalign)
  );
  always_comb begin
    state_next = BOOT;
    state_next = (st == RUN) ? (bus.i_halt ? HALT : RUN) :
                 (st == HALT) ? ((bus.i_trap || misalign || bus.i_resume) ? RUN : HALT) :
                 ((bus.i_halt && !bus.i_trap) ? HALT : RUN);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      misalign_q <= misalign;
    end
  end
  assign bus.o_pc       = pc;
  assign bus.o_pc_inc   = pc_inc;
  assign bus.o_valid    = (st == RUN);
  assign bus.o_halted   = (st == HALT);
  assign bus.o_misalign = misalign_q;
endmodule
